load_store_unit: RTL and testbench
==================================

# load_store_unit

Sits between the core's execute stage and the byte-addressed data memory, directly upstream of it. Accepts one load or store per handshake and decodes RISC-V funct3 into the memory's address/write_length/wr_data protocol. Left-justifies store data and extracts/sign-extends load data from the memory's big-endian 32-bit read word. Rejects illegal, misaligned or out-of-range accesses without touching memory, and returns every result through a valid/ready response channel.

## Interface
- MEM_BYTES, default 5096: number of implemented memory bytes; an access is in range iff addr + size <= MEM_BYTES.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  2  0 OK, 1 misaligned, 2 illegal funct3, 3 out of range.
- mem_address  out  32  to memory address.
- mem_wr_data  out  32  to memory wr_data; bytes are taken from bit 31 downward.
- mem_wr_enable  out  1  to memory wr_enable.
- mem_write_length  out  2  0 byte, 1 half, 2 word.
- mem_read_data  in  32  combinational memory read: {m[a], m[a+1], m[a+2], m[a+3]}.

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - ACCESS: one cycle; memory driven.
  - RESP: rsp_valid=1.
- IDLE transition: on req_valid && req_ready, latch we, funct3, addr and wdata, then classify the request.
- Classification, in priority order:
  - Illegal (err 2): funct3 ∈ {011, 110, 111}, or store with funct3[2]=1.
  - Misaligned (err 1): half with addr[0]≠0, or word with addr[1:0]≠0.
  - Out of range (err 3): addr + size > MEM_BYTES, with size 1/2/4. Compute in 33 bits so no wrap.
- Any error: go to RESP with rsp_err set and rsp_rdata=0. No ACCESS state, and mem_wr_enable is never asserted.
- Otherwise go to ACCESS:
  - mem_address = latched addr; mem_write_length = funct3[1:0].
  - Store: mem_wr_enable=1. mem_wr_data = {wdata[7:0],24'h0} for SB, {wdata[15:0],16'h0} for SH, wdata for SW. The memory commits at the end of ACCESS.
  - Load: mem_wr_enable=0. At the end of ACCESS, capture into rsp_rdata:
    - LB: sext(rd[31:24])
    - LBU: zext(rd[31:24])
    - LH: sext(rd[31:16])
    - LHU: zext(rd[31:16])
    - LW: rd
- RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE and clear rsp_rdata/rsp_err.
- req_valid outside IDLE is ignored, since req_ready=0. One request is outstanding at a time.
- mem_wr_enable is 1 only in ACCESS with a store; it is 0 in every other state.
- mem_address, mem_wr_data and mem_write_length keep their last value outside ACCESS.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE, so req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - mem_address=0, mem_wr_data=0, mem_wr_enable=0, mem_write_length=0.
- Good access: request accepted at edge E0 → ACCESS during cycle after E0 → rsp_valid high after E1. Latency is 2 cycles from acceptance to response.
- Error: rsp_valid high after E0, latency 1.
- With rsp_ready held high, req_ready is high again 3 cycles (good access) or 2 cycles (error) after acceptance. No back-to-back acceptance.
- Reset asserted during ACCESS: mem_wr_enable drops immediately and the store is not committed if reset precedes the edge. No response is produced.
- Reset asserted during RESP: the pending response is discarded.

## Structure
- Package lsu_pkg holds:
  - funct3 constants.
  - Write-length codes: WL_BYTE=2'd0, WL_HALF=2'd1, WL_WORD=2'd2.
  - rsp_err codes.
  - State encoding: IDLE, ACCESS, RESP.
- Sub-module lsu_load_align: purely combinational (funct3, mem_read_data) → 32-bit extended load value. It is unit-testable alone.
- The top level holds the FSM, request latches, classification and store packing.

## Test plan
- SW addr 0x10, wdata 0xDEADBEEF → ACCESS cycle shows mem_wr_enable=1, mem_write_length=2, mem_address=0x10, mem_wr_data=0xDEADBEEF; rsp_err=0, rsp_rdata=0.
- Then LB 0x10 → 0xFFFFFFDE; LBU 0x13 → 0x000000EF; LH 0x12 → 0xFFFFBEEF; LHU 0x10 → 0x0000DEAD; LW 0x10 → 0xDEADBEEF. Each response arrives exactly 2 cycles after acceptance.
- SB addr 0x20, wdata 0x12345678 → mem_wr_data=0x78000000, mem_write_length=0. Then LW 0x20 → upper byte 0x78.
- Error checks; in each case the response arrives after 1 cycle and mem_wr_enable is never 1:
  - SH 0x11 → rsp_err=1.
  - funct3 011 → rsp_err=2.
  - SB with funct3 100 → rsp_err=2.
  - LW 5096 → rsp_err=3.
  - LW 5092 → rsp_err=0.
- Backpressure: rsp_ready=0 for 5 cycles during RESP → rsp_valid, rsp_rdata and rsp_err stable, req_ready=0, and req_valid pulses ignored. After rsp_ready, return to IDLE.
- Assert rst_n=0 mid-ACCESS of SW 0x30 → mem_wr_enable falls asynchronously, LW 0x30 after reset returns the old contents, and all outputs equal their reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 opcodes, memory write
// lengths, response error codes and FSM states.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WL_BYTE = 2'd0;
  localparam logic [1:0] WL_HALF = 2'd1;
  localparam logic [1:0] WL_WORD = 2'd2;

  localparam logic [1:0] ERR_OK         = 2'd0;
  localparam logic [1:0] ERR_MISALIGNED = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL    = 2'd2;
  localparam logic [1:0] ERR_RANGE      = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Access width in bytes for a write-length code (funct3[1:0]).
  function automatic logic [2:0] access_size(input logic [1:0] len);
    case (len)
      WL_BYTE: access_size = 3'd1;
      WL_HALF: access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and extends a load value from the memory's big-endian read word;
// the addressed byte always sits in bits [31:24].
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_read_data,
  output logic [31:0] load_value
);

  always_comb begin
    load_value = mem_read_data;
    case (funct3)
      F3_B:    load_value = {{24{mem_read_data[31]}}, mem_read_data[31:24]};
      F3_BU:   load_value = {24'h0, mem_read_data[31:24]};
      F3_H:    load_value = {{16{mem_read_data[31]}}, mem_read_data[31:16]};
      F3_HU:   load_value = {16'h0, mem_read_data[31:16]};
      default: load_value = mem_read_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: classifies a core request, drives the
// byte-addressed memory for one cycle and returns the result on a valid/ready channel.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 5096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_enable,
  output logic [1:0]  mem_write_length,
  input  logic [31:0] mem_read_data
);

  state_t      state;
  logic        we_reg;
  logic [2:0]  funct3_reg;

  logic [2:0]  req_size;
  logic [32:0] req_end;
  logic [1:0]  req_err;
  logic [31:0] store_data;
  logic [31:0] load_value;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // The end address is formed in 33 bits so an access near 2^32 cannot wrap into range.
  always_comb begin
    req_size = access_size(req_funct3[1:0]);
    req_end  = {1'b0, req_addr} + {30'd0, req_size};
    req_err  = ERR_OK;
    if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2])) begin
      req_err = ERR_ILLEGAL;
    end else if ((req_funct3[1:0] == WL_HALF && req_addr[0]) ||
                 (req_funct3[1:0] == WL_WORD && req_addr[1:0] != 2'b00)) begin
      req_err = ERR_MISALIGNED;
    end else if (req_end > 33'(MEM_BYTES)) begin
      req_err = ERR_RANGE;
    end
  end

  // Store data is left-justified: the memory takes bytes from bit 31 downward.
  always_comb begin
    case (req_funct3[1:0])
      WL_BYTE: store_data = {req_wdata[7:0], 24'h0};
      WL_HALF: store_data = {req_wdata[15:0], 16'h0};
      default: store_data = req_wdata;
    endcase
  end

  lsu_load_align u_load_align (
    .funct3        (funct3_reg),
    .mem_read_data (mem_read_data),
    .load_value    (load_value)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      we_reg           <= 1'b0;
      funct3_reg       <= 3'b000;
      rsp_rdata        <= 32'h0;
      rsp_err          <= ERR_OK;
      mem_address      <= 32'h0;
      mem_wr_data      <= 32'h0;
      mem_wr_enable    <= 1'b0;
      mem_write_length <= WL_BYTE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_reg     <= req_we;
            funct3_reg <= req_funct3;
            if (req_err != ERR_OK) begin
              rsp_err   <= req_err;
              rsp_rdata <= 32'h0;
              state     <= RESP;
            end else begin
              mem_address      <= req_addr;
              mem_write_length <= req_funct3[1:0];
              mem_wr_enable    <= req_we;
              if (req_we) begin
                mem_wr_data <= store_data;
              end
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // Memory commits a store on this edge; a load is sampled on it.
          mem_wr_enable <= 1'b0;
          rsp_rdata     <= we_reg ? 32'h0 : load_value;
          rsp_err       <= ERR_OK;
          state         <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= ERR_OK;
            state     <= IDLE;
          end
        end
        default: begin
          mem_wr_enable <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural big-endian byte memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned MEM_BYTES = 5096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_wr_data;
  logic        mem_wr_enable;
  logic [1:0]  mem_write_length;
  logic [31:0] mem_read_data;

  int checks = 0;
  int passed = 0;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .mem_address      (mem_address),
    .mem_wr_data      (mem_wr_data),
    .mem_wr_enable    (mem_wr_enable),
    .mem_write_length (mem_write_length),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  // Behavioural memory: combinational big-endian read, write committed on posedge.
  logic [7:0] mem [0:MEM_BYTES-1];
  logic       mem_init_done = 1'b0;

  always_comb begin
    mem_read_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      logic [32:0] idx;
      idx = {1'b0, mem_address} + 33'(k);
      mem_read_data[31-8*k -: 8] = (idx < 33'(MEM_BYTES)) ? mem[idx[12:0]] : 8'h00;
    end
  end

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= 8'h00;
      mem_init_done <= 1'b1;
    end else if (mem_wr_enable) begin
      for (int k = 0; k < 4; k++) begin
        logic [32:0] widx;
        int nbytes;
        nbytes = (mem_write_length == WL_BYTE) ? 1 : (mem_write_length == WL_HALF) ? 2 : 4;
        widx = {1'b0, mem_address} + 33'(k);
        if (k < nbytes && widx < 33'(MEM_BYTES)) mem[widx[12:0]] <= mem_wr_data[31-8*k -: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Results of the most recent transaction.
  int          lat;
  logic        any_we;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [1:0]  acc_len;
  logic [31:0] r_rdata;
  logic [1:0]  r_err;

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    int w;
    w = 0;
    while (!req_ready && w < 10) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready) chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat       = 1;
    acc_we    = mem_wr_enable;
    acc_addr  = mem_address;
    acc_wdata = mem_wr_data;
    acc_len   = mem_write_length;
    any_we    = mem_wr_enable;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
      any_we = any_we | mem_wr_enable;
    end
    r_rdata = rsp_rdata;
    r_err   = rsp_err;
    $display("txn we=%0b f3=%03b addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             we, f3, addr, wd, r_rdata, r_err, lat);
    if (rsp_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp);
    do_req(1'b0, f3, addr, 32'h0);
    chk(tag, r_rdata, exp);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
  endtask

  task automatic err_chk(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [1:0] exp_err);
    do_req(we, f3, addr, 32'hA5A5A5A5);
    chk(tag, {30'b0, r_err}, {30'b0, exp_err});
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_we"}, {31'b0, any_we}, 32'd0);
    chk({tag, "_rdata"}, r_rdata, 32'h0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"}, {30'b0, rsp_err}, 32'd0);
    chk({tag, "_mem_address"}, mem_address, 32'h0);
    chk({tag, "_mem_wr_data"}, mem_wr_data, 32'h0);
    chk({tag, "_mem_wr_enable"}, {31'b0, mem_wr_enable}, 32'd0);
    chk({tag, "_mem_write_length"}, {30'b0, mem_write_length}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    #12;
    reset_vals("rst");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Word store then every load flavour from the same word.
    do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    chk("sw_we", {31'b0, acc_we}, 32'd1);
    chk("sw_len", {30'b0, acc_len}, 32'd2);
    chk("sw_addr", acc_addr, 32'h10);
    chk("sw_wdata", acc_wdata, 32'hDEADBEEF);
    chk("sw_err", {30'b0, r_err}, 32'd0);
    chk("sw_rdata", r_rdata, 32'h0);
    chk("sw_lat", 32'(lat), 32'd2);

    load_chk("lb", F3_B, 32'h10, 32'hFFFFFFDE);
    load_chk("lbu", F3_BU, 32'h13, 32'h000000EF);
    load_chk("lh", F3_H, 32'h12, 32'hFFFFBEEF);
    load_chk("lhu", F3_HU, 32'h10, 32'h0000DEAD);
    load_chk("lw", F3_W, 32'h10, 32'hDEADBEEF);

    // Byte store is left-justified and only writes one byte.
    do_req(1'b1, F3_B, 32'h20, 32'h12345678);
    chk("sb_wdata", acc_wdata, 32'h78000000);
    chk("sb_len", {30'b0, acc_len}, 32'd0);
    chk("sb_we", {31'b0, acc_we}, 32'd1);
    load_chk("lw_sb", F3_W, 32'h20, 32'h78000000);

    do_req(1'b1, F3_H, 32'h32, 32'hCAFE1234);
    chk("sh_wdata", acc_wdata, 32'h12340000);
    do_req(1'b1, F3_W, 32'h30, 32'h11223344);
    load_chk("lh_sh", F3_H, 32'h32, 32'h00003344);

    err_chk("sh_mis", 1'b1, F3_H, 32'h11, ERR_MISALIGNED);
    err_chk("lw_mis", 1'b0, F3_W, 32'h12, ERR_MISALIGNED);
    err_chk("f3_011", 1'b0, 3'b011, 32'h10, ERR_ILLEGAL);
    err_chk("sb_f3_100", 1'b1, 3'b100, 32'h10, ERR_ILLEGAL);
    err_chk("f3_110_mis", 1'b0, 3'b110, 32'h11, ERR_ILLEGAL);
    err_chk("lw_range", 1'b0, F3_W, 32'd5096, ERR_RANGE);
    err_chk("lb_wrap", 1'b0, F3_B, 32'hFFFFFFFF, ERR_RANGE);
    do_req(1'b0, F3_W, 32'd5092, 32'h0);
    chk("lw_last_err", {30'b0, r_err}, 32'd0);
    chk("lw_last_lat", 32'(lat), 32'd2);
    do_req(1'b0, F3_B, 32'd5095, 32'h0);
    chk("lb_last_err", {30'b0, r_err}, 32'd0);

    // Backpressure: response held, new requests ignored.
    rsp_ready = 1'b0;
    do_req(1'b0, F3_W, 32'h10, 32'h0);
    chk("bp_rdata0", r_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h40;
      req_wdata = 32'h55AA55AA;
      @(posedge clk); #1;
      chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_err", {30'b0, rsp_err}, 32'd0);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_wr_enable", {31'b0, mem_wr_enable}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_release_rdata", rsp_rdata, 32'h0);
    load_chk("bp_no_write", F3_W, 32'h40, 32'h0);

    // Reset while a response is pending discards it.
    rsp_ready = 1'b0;
    do_req(1'b0, F3_W, 32'h10, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_resp_rdata", rsp_rdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a store aborts the write.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h30;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_acc_we_before", {31'b0, mem_wr_enable}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    reset_vals("rst_acc");
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_acc_no_rsp", {31'b0, rsp_valid}, 32'd0);
    load_chk("rst_acc_old", F3_W, 32'h30, 32'h11223344);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
